// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the instruction/data memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/addr_ok/data_ok memory bus; master issues, slave answers
interface mem_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_arb_sel.sv
// rtl/mem_arb_sel.sv - requester selection; MEM_ARB_STARVE_GUARD_EN adds the inst starvation counter
module mem_arb_sel
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   inst_req,
  input  logic   data_req,
  input  logic   grant,
  output owner_t sel
);

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;
  logic       force_inst;

  assign force_inst = (starve_cnt == 3'(STARVE_LIMIT));

  always_comb begin
    sel = OWN_NONE;
    if (inst_req && (force_inst || !data_req)) sel = OWN_INST;
    else if (data_req)                         sel = OWN_DATA;
  end

  // Counts data grants that passed over a waiting inst request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (!inst_req || sel == OWN_INST) starve_cnt <= '0;
      else if (starve_cnt != 3'd7)      starve_cnt <= starve_cnt + 3'd1;
    end
  end
`else
  logic unused_sel;

  always_comb begin
    sel = OWN_NONE;
    if (data_req)      sel = OWN_DATA;
    else if (inst_req) sel = OWN_INST;
  end

  assign unused_sel = ^{clk, resetn, grant, 32'(STARVE_LIMIT)};
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter onto one memory port, one transaction outstanding
// MEM_ARB_STARVE_GUARD_EN enables forced inst grants after STARVE_LIMIT data grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          resetn,
  mem_arbiter_if.slave  inst,
  mem_arbiter_if.slave  data,
  mem_arbiter_if.master m
);

  state_t state, state_nxt;
  owner_t owner, owner_nxt;
  owner_t sel, cur;
  logic   grant;
  logic   owner_req;

  mem_arb_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
    .clk      (clk),
    .resetn   (resetn),
    .inst_req (inst.req),
    .data_req (data.req),
    .grant    (grant),
    .sel      (sel)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      owner <= OWN_NONE;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  assign owner_req = (owner == OWN_INST) ? inst.req :
                     (owner == OWN_DATA) ? data.req : 1'b0;

  // cur names whoever is driving the memory port this cycle.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    grant     = 1'b0;
    cur       = OWN_NONE;
    if (resetn) begin
      case (state)
        IDLE: begin
          if (sel != OWN_NONE) begin
            grant     = 1'b1;
            cur       = sel;
            owner_nxt = sel;
            state_nxt = m.addr_ok ? WAIT : ADDR;
          end
        end
        ADDR: begin
          if (owner_req) begin
            cur = owner;
            if (m.addr_ok) state_nxt = WAIT;
          end else begin
            state_nxt = IDLE;
            owner_nxt = OWN_NONE;
          end
        end
        WAIT: begin
          if (m.data_ok) begin
            state_nxt = IDLE;
            owner_nxt = OWN_NONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          owner_nxt = OWN_NONE;
        end
      endcase
    end
  end

  always_comb begin
    m.req   = 1'b0;
    m.wr    = 1'b0;
    m.size  = 2'd0;
    m.addr  = 32'd0;
    m.wdata = 32'd0;
    case (cur)
      OWN_INST: begin
        m.req   = 1'b1;
        m.wr    = inst.wr;
        m.size  = inst.size;
        m.addr  = inst.addr;
        m.wdata = inst.wdata;
      end
      OWN_DATA: begin
        m.req   = 1'b1;
        m.wr    = data.wr;
        m.size  = data.size;
        m.addr  = data.addr;
        m.wdata = data.wdata;
      end
      default: ;
    endcase
  end

  assign inst.addr_ok = (cur == OWN_INST) && m.addr_ok;
  assign data.addr_ok = (cur == OWN_DATA) && m.addr_ok;
  assign inst.data_ok = resetn && (state == WAIT) && (owner == OWN_INST) && m.data_ok;
  assign data.data_ok = resetn && (state == WAIT) && (owner == OWN_DATA) && m.data_ok;
  assign inst.rdata   = m.rdata;
  assign data.rdata   = m.rdata;

endmodule
